mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface: turns a core load/store (address, funct3, write data) into a word-aligned request with byte enables, then waits for the memory acknowledge.
- On a load it selects the right byte/half/word lane and sign- or zero-extends it; on a store it replicates the data across byte lanes.
- Sits between the control/ALU datapath and the data memory responder. Flags misaligned accesses, illegal funct3 codes and memory timeouts, and never issues a memory request for a faulty access.

Parameters:
- ADDR_WIDTH, 32, byte-address width; bits [1:0] select the byte lane.
- TIMEOUT, 16, maximum number of REQ cycles waited for iMemAck (must be >= 1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- iValid  input  1  core access request.
- iMemWrite  input  1  1 = store, 0 = load.
- iFunct3  input  3  RV32I width/sign code.
- iAddr  input  ADDR_WIDTH  byte address (ALU result).
- iWriteData  input  32  store data (rs2).
- oReady  output  1  unit idle; accepts iValid this cycle.
- oRespValid  output  1  one-cycle completion pulse.
- oReadData  output  32  extended load result; 0 for stores and faults.
- oAddrErr  output  1  misaligned address or illegal funct3; valid with oRespValid.
- oTimeout  output  1  no ack within TIMEOUT cycles; valid with oRespValid.
- oMemReq  output  1  memory request, held until ack or timeout.
- oMemWE  output  1  write enable, valid with oMemReq.
- oMemAddr  output  ADDR_WIDTH  {addr[ADDR_WIDTH-1:2], 2'b00}.
- oMemWData  output  32  lane-replicated store data.
- oMemBE  output  4  byte enables.
- iMemAck  input  1  responder completes the access this cycle.
- iMemRData  input  32  read word, valid when iMemAck=1.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high. On a rising edge with rst=1, state goes to IDLE and every registered output clears: oMemReq, oMemWE, oRespValid, oAddrErr, oTimeout = 0; oReadData, oMemAddr, oMemWData, oMemBE = 0. oReady = 1 once in IDLE.
- States: IDLE, REQ, DONE. oReady = (state == IDLE). iValid is ignored outside IDLE.
- Accept (IDLE, iValid=1, edge N): latch iMemWrite, iFunct3, iAddr, iWriteData.
  - Legal and aligned: go to REQ at N+1, oMemReq=1.
  - Fault: go directly to DONE at N+1 with oAddrErr=1 and no memory request.
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal funct3 for stores: 000 SB, 001 SH, 010 SW. All other codes are illegal and set oAddrErr.
- Alignment: a halfword with addr[0]=1 is misaligned; a word with addr[1:0]!=0 is misaligned; bytes are always aligned.
- Byte enables (loads and stores alike):
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1], 1'b0}
  - word: 4'b1111
- Store data: SB drives {4{wd[7:0]}}, SH drives {2{wd[15:0]}}, SW drives wd.
- Load request: oMemWE=0 and oMemWData=0.
- REQ state: oMemReq and all memory outputs are held stable until iMemAck=1.
  - On the ack edge M, capture iMemRData, go to DONE at M+1.
  - Timeout counter is cleared on entry to REQ and increments each REQ cycle without ack. If the counter equals TIMEOUT-1 with no ack, go to DONE with oTimeout=1. REQ therefore lasts at most TIMEOUT cycles.
  - If ack and final count occur in the same cycle, the ack wins and oTimeout=0.
- Load extraction (at DONE): pick the lane by addr[1:0] (byte) or addr[1] (half). LB/LH sign-extend; LBU/LHU zero-extend.
- DONE state: lasts exactly one cycle with oRespValid=1, then returns to IDLE. oReadData, oAddrErr and oTimeout are valid only while oRespValid=1 and are 0 otherwise.
- Latency: a good access accepted at edge N with ack at the first REQ cycle gives oRespValid at cycle N+2 and oReady again at N+3. A faulted access gives oRespValid at N+1.
- Reset during REQ: the request is abandoned, oMemReq drops at the reset edge, and any later iMemAck seen in IDLE is ignored.
- iMemAck outside REQ is ignored. The address wraps naturally at ADDR_WIDTH; no carry is produced.

Test Plan:
- LB, addr 0x1003, ack next cycle with iMemRData 0x80FF1234 -> oMemAddr 0x1000, BE 1000, oReadData 0xFFFFFF80, oRespValid at N+2 for exactly 1 cycle.
- LHU, addr 0x0102, iMemRData 0x80FF1234 -> BE 1100, oReadData 0x000080FF; LH on the same access -> 0xFFFF80FF.
- SB, addr 0x0201, wd 0x000000AB -> oMemWE=1, oMemWData 0xABABABAB, BE 0010; ack after 3 wait cycles -> oMemReq held stable 4 cycles, then oReadData 0.
- LW at 0x0102, then funct3=011 at 0x0100 -> no oMemReq for either; oRespValid at N+1 with oAddrErr=1 and oReadData 0.
- TIMEOUT=4, SW with no ack -> oMemReq high 4 cycles, then oRespValid with oTimeout=1. Repeat with ack on the 4th REQ cycle -> oTimeout=0 and normal completion.
- rst=1 during the 2nd REQ cycle, then iMemAck pulse one cycle later -> oMemReq=0 after the reset edge, no oRespValid, oReady=1, and the next LW completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
//======================================================================
// mem_access_unit_if
// Bundles the core-side access handshake and the data-memory request
// bus of mem_access_unit.
// Revision: 1.0 - initial release
//======================================================================
`default_nettype none

interface mem_access_unit_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  iValid;
   logic                  iMemWrite;
   logic [2:0]            iFunct3;
   logic [ADDR_WIDTH-1:0] iAddr;
   logic [31:0]           iWriteData;
   logic                  oReady;
   logic                  oRespValid;
   logic [31:0]           oReadData;
   logic                  oAddrErr;
   logic                  oTimeout;
   logic                  oMemReq;
   logic                  oMemWE;
   logic [ADDR_WIDTH-1:0] oMemAddr;
   logic [31:0]           oMemWData;
   logic [3:0]            oMemBE;
   logic                  iMemAck;
   logic [31:0]           iMemRData;

   // View taken by the access unit: serves the core, drives the memory bus.
   modport slave (
      input  iValid, iMemWrite, iFunct3, iAddr, iWriteData, iMemAck, iMemRData,
      output oReady, oRespValid, oReadData, oAddrErr, oTimeout,
             oMemReq, oMemWE, oMemAddr, oMemWData, oMemBE
   );

   // View taken by the surroundings: the core and the memory responder.
   modport master (
      output iValid, iMemWrite, iFunct3, iAddr, iWriteData, iMemAck, iMemRData,
      input  oReady, oRespValid, oReadData, oAddrErr, oTimeout,
             oMemReq, oMemWE, oMemAddr, oMemWData, oMemBE
   );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
//======================================================================
// mem_access_unit
// Load/store initiator: decodes a core access into a word-aligned memory
// request with byte enables, waits for the acknowledge (bounded by
// TIMEOUT), and returns the lane-extracted, extended load result.
// Revision: 1.0 - initial release
//======================================================================
`default_nettype none

module mem_access_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  wire logic        clk,
   input  wire logic        rst,
   mem_access_unit_if.slave bus
);

   localparam int            CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state, state_next;
   logic [CNT_W-1:0]      wait_cnt;
   logic                  is_store;
   logic [2:0]            funct3;
   logic [1:0]            lane;
   logic                  req, we, resp_valid, addr_err, timed_out;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           wdata, read_data;
   logic [3:0]            be;

   logic                  legal, misaligned, fault, last_wait;
   logic [3:0]            be_new;
   logic [31:0]           wdata_new;
   logic [7:0]            lane_byte;
   logic [15:0]           lane_half;
   logic [31:0]           load_data;

   assign last_wait = (wait_cnt == LAST_WAIT);

   // Decode the incoming access: legality, alignment, byte enables, store lanes.
   always_comb begin
      legal      = 1'b0;
      misaligned = 1'b0;
      be_new     = 4'b0000;
      wdata_new  = '0;
      case (bus.iFunct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = !bus.iMemWrite;
         default:                legal = 1'b0;
      endcase
      case (bus.iFunct3[1:0])
         2'b00: begin
            be_new    = 4'b0001 << bus.iAddr[1:0];
            wdata_new = {4{bus.iWriteData[7:0]}};
         end
         2'b01: begin
            misaligned = bus.iAddr[0];
            be_new     = 4'b0011 << {bus.iAddr[1], 1'b0};
            wdata_new  = {2{bus.iWriteData[15:0]}};
         end
         2'b10: begin
            misaligned = |bus.iAddr[1:0];
            be_new     = 4'b1111;
            wdata_new  = bus.iWriteData;
         end
         default: ;
      endcase
      if (!bus.iMemWrite) wdata_new = '0;
      fault = !legal || misaligned;
   end

   // Pick the addressed lane of the returned word and extend it.
   always_comb begin
      lane_byte = bus.iMemRData[{lane, 3'b000} +: 8];
      lane_half = lane[1] ? bus.iMemRData[31:16] : bus.iMemRData[15:0];
      load_data = '0;
      if (!is_store) begin
         case (funct3)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b010:  load_data = bus.iMemRData;
            3'b100:  load_data = {24'd0, lane_byte};
            3'b101:  load_data = {16'd0, lane_half};
            default: load_data = '0;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state: faults skip the memory phase; ack beats the final wait count.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.iValid) state_next = fault ? DONE : REQ;
         REQ:     if (bus.iMemAck || last_wait) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: latch the access, hold the request, build the one-cycle response.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt   <= '0;
         is_store   <= 1'b0;
         funct3     <= 3'b000;
         lane       <= 2'b00;
         req        <= 1'b0;
         we         <= 1'b0;
         mem_addr   <= '0;
         wdata      <= '0;
         be         <= 4'b0000;
         resp_valid <= 1'b0;
         addr_err   <= 1'b0;
         timed_out  <= 1'b0;
         read_data  <= '0;
      end else begin
         resp_valid <= 1'b0;
         addr_err   <= 1'b0;
         timed_out  <= 1'b0;
         read_data  <= '0;
         case (state)
            IDLE: begin
               if (bus.iValid) begin
                  is_store <= bus.iMemWrite;
                  funct3   <= bus.iFunct3;
                  lane     <= bus.iAddr[1:0];
                  wait_cnt <= '0;
                  if (fault) begin
                     resp_valid <= 1'b1;
                     addr_err   <= 1'b1;
                  end else begin
                     req      <= 1'b1;
                     we       <= bus.iMemWrite;
                     mem_addr <= {bus.iAddr[ADDR_WIDTH-1:2], 2'b00};
                     wdata    <= wdata_new;
                     be       <= be_new;
                  end
               end
            end
            REQ: begin
               if (bus.iMemAck || last_wait) begin
                  req        <= 1'b0;
                  we         <= 1'b0;
                  mem_addr   <= '0;
                  wdata      <= '0;
                  be         <= 4'b0000;
                  resp_valid <= 1'b1;
                  if (bus.iMemAck) read_data <= load_data;
                  else             timed_out <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.oReady     = (state == IDLE);
   assign bus.oRespValid = resp_valid;
   assign bus.oReadData  = read_data;
   assign bus.oAddrErr   = addr_err;
   assign bus.oTimeout   = timed_out;
   assign bus.oMemReq    = req;
   assign bus.oMemWE     = we;
   assign bus.oMemAddr   = mem_addr;
   assign bus.oMemWData  = wdata;
   assign bus.oMemBE     = be;

endmodule

`default_nettype wire
